// File: rtl/sha256_pkg.sv
// Shared SHA-256 types, schedule FSM states and sigma helpers.
// Imported by the message-schedule reader and its word generator.
package sha256_pkg;

  typedef logic [31:0]  word_t;
  typedef logic [511:0] block_t;

  typedef enum logic {
    IDLE,
    STREAM
  } sched_state_e;

  localparam int SCHED_WINDOW = 16;

  // sigma0: ROTR7 ^ ROTR18 ^ SHR3
  function automatic word_t sigma0(input word_t x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  // sigma1: ROTR17 ^ ROTR19 ^ SHR10
  function automatic word_t sigma1(input word_t x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

endpackage

// File: rtl/schedule_word_gen.sv
// Combinational next-word generator for the SHA-256 schedule window.
// Produces W[t+16] from W[t], W[t+1], W[t+9], W[t+14].
module schedule_word_gen
  import sha256_pkg::*;
(
  input  logic [31:0] i_w0,
  input  logic [31:0] i_w1,
  input  logic [31:0] i_w9,
  input  logic [31:0] i_w14,
  output logic [31:0] o_wnext
);

  // Sum wraps naturally modulo 2^32.
  always_comb begin
    o_wnext = sigma1(i_w14) + i_w9 + sigma0(i_w1) + i_w0;
  end

endmodule

// File: rtl/message_schedule_reader.sv
// Streams SHA-256 schedule words W[0..NUM_ROUNDS-1] from a 16-word window.
// Optional stall counter enabled by defining SCHED_STALL_CNT_EN.
module message_schedule_reader
  import sha256_pkg::*;
#(
  parameter int NUM_ROUNDS  = 64,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   load,
  output logic                   load_ready,
  input  logic [511:0]           block,
  input  logic                   abort,
  output logic                   w_valid,
  input  logic                   w_ready,
  output logic [31:0]            w_data,
  output logic [5:0]             w_index,
`ifdef SCHED_STALL_CNT_EN
  output logic [STALL_CNT_W-1:0] stall_count,
`endif
  output logic                   done
);

  localparam logic [5:0] LAST_IDX = 6'(NUM_ROUNDS - 1);

  sched_state_e r_state;
  word_t        r_win [SCHED_WINDOW];
  logic [5:0]   r_idx;
  logic         r_done;

  logic  w_stream;
  logic  w_hs;
  logic  w_last;
  logic  w_ld_rdy;
  logic  w_ld_acc;
  word_t w_next;

  schedule_word_gen u_gen (
    .i_w0    (r_win[0]),
    .i_w1    (r_win[1]),
    .i_w9    (r_win[9]),
    .i_w14   (r_win[14]),
    .o_wnext (w_next)
  );

  // Handshake and load-acceptance qualifiers; abort blocks a load.
  always_comb begin
    w_stream = (r_state == STREAM);
    w_hs     = w_stream & w_ready;
    w_last   = (r_idx == LAST_IDX);
    w_ld_rdy = ~w_stream | (w_hs & w_last);
    w_ld_acc = load & w_ld_rdy & ~abort;
  end

  // Schedule FSM: window shift, index, done pulse and reload.
  always_ff @(posedge clk) begin
    if (n_rst) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_done  <= 1'b0;
      for (int i = 0; i < SCHED_WINDOW; i++) r_win[i] <= '0;
    end else begin
      r_done <= 1'b0;
      if (abort) begin
        r_state <= IDLE;
      end else begin
        if (w_hs) begin
          if (w_last) begin
            r_done  <= 1'b1;
            r_state <= IDLE;
          end else begin
            for (int i = 0; i < SCHED_WINDOW - 1; i++)
              r_win[i] <= r_win[i+1];
            r_win[SCHED_WINDOW-1] <= w_next;
            r_idx <= r_idx + 6'd1;
          end
        end
        if (w_ld_acc) begin
          for (int i = 0; i < SCHED_WINDOW; i++)
            r_win[i] <= block[511-32*i -: 32];
          r_idx   <= '0;
          r_state <= STREAM;
        end
      end
    end
  end

  assign load_ready = w_ld_rdy;
  assign w_valid    = w_stream;
  assign w_data     = r_win[0];
  assign w_index    = r_idx;
  assign done       = r_done;

`ifdef SCHED_STALL_CNT_EN
  logic [STALL_CNT_W-1:0] r_stall;

  // Saturating count of valid cycles the round engine refused.
  always_ff @(posedge clk) begin
    if (n_rst || w_ld_acc) begin
      r_stall <= '0;
    end else if (w_stream && !w_ready && !(&r_stall)) begin
      r_stall <= r_stall + 1'b1;
    end
  end

  assign stall_count = r_stall;
`endif

endmodule

// File: doc/message_schedule_reader.md
Name: message_schedule_reader

Overview:
- Consumer side of the SHA-256 message-schedule expansion for the miner's compression core.
- Accepts one 512-bit padded block and streams W[0]..W[NUM_ROUNDS-1] one word per handshake to the round engine.
- Uses a 16-word sliding window and computes W[t+16] on the fly; no 64-word store.
- Word index tracks the round count that the compression loop consumes.

Parameters:
- NUM_ROUNDS, 64, number of schedule words streamed per block; legal range 17..64.
- STALL_CNT_W, 16, stall counter width; used only with the optional feature.

Ports:
- clk  input  1  system clock
- n_rst  input  1  synchronous, active-high reset; asserted = 1, sampled on rising clk
- load  input  1  start request; accepted only when load_ready=1
- load_ready  output  1  block can be accepted this cycle
- block  input  512  padded message block; word 0 = block[511:480], big-endian word order
- abort  input  1  drop the current block, return to IDLE
- w_valid  output  1  w_data/w_index valid
- w_ready  input  1  round engine accepts the word
- w_data  output  32  current schedule word W[t]
- w_index  output  6  t, 0..NUM_ROUNDS-1
- done  output  1  one-cycle pulse after word NUM_ROUNDS-1 is accepted

Behaviour:
- Reset values: state=IDLE, all window words 0, w_valid=0, w_index=0, w_data=0, done=0, load_ready=1.
- FSM has two states, IDLE and STREAM.
- IDLE:
  - w_valid=0, load_ready=1.
  - On load: win[i] <= block word i for i=0..15, w_index<=0, state<=STREAM.
  - First word is valid the cycle after load (latency 1).
- STREAM:
  - w_valid=1, w_data=win[0].
  - Handshake = w_valid & w_ready. With no handshake, all state holds and w_data is stable.
  - Handshake with w_index < NUM_ROUNDS-1:
    - win[i] <= win[i+1] for i=0..14; win[15] <= s1(win[14]) + win[9] + s0(win[1]) + win[0] (mod 2^32); w_index++.
    - s0(x) = ROTR7 ^ ROTR18 ^ SHR3; s1(x) = ROTR17 ^ ROTR19 ^ SHR10.
  - Handshake with w_index == NUM_ROUNDS-1: done=1 next cycle; state<=IDLE.
- load_ready = (state==IDLE) | (state==STREAM & handshake & w_index==NUM_ROUNDS-1).
- Back-to-back blocks: load on the final-handshake cycle loads the new block and stays in STREAM with w_index=0. done still pulses for the finished block. No bubble between blocks.
- load while load_ready=0 is ignored; no queueing.
- abort has priority over handshake and load:
  - next cycle state=IDLE, w_valid=0, no done pulse; window contents are don't-care.
  - abort in IDLE is a no-op.
- n_rst has priority over everything, including in the middle of a block; outputs return to reset values the next cycle.
- w_index wraps only through reload; it never exceeds NUM_ROUNDS-1.
- done is never asserted together with w_valid for the same index.

Optional Feature:
- Macro: SCHED_STALL_CNT_EN.
- Defined:
  - Adds output stall_count [STALL_CNT_W-1:0].
  - Increments each cycle with w_valid=1 & w_ready=0; saturates at all-ones.
  - Clears on n_rst and on each accepted load.
- Not defined: port and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package sha256_pkg holds:
  - typedef word_t (logic [31:0]) and typedef block_t (logic [511:0]);
  - schedule state enum {IDLE, STREAM};
  - functions sigma0/sigma1;
  - constant SCHED_WINDOW = 16.
- One natural sub-module, schedule_word_gen:
  - combinational; inputs win[0], win[1], win[9], win[14]; output the next W word.
  - Instantiated once and shared with future pipelined variants.

Test Plan:
- "abc" padded block (0x61626380, 14×0, 0x00000018), w_ready=1 continuously -> W0=61626380, W15=00000018, W16=61626380, W17=000F0000, W18=7DA86405, W19=600003C6; 64 words on 64 consecutive cycles; done pulses the cycle after w_index=63.
- Same block with w_ready toggled 1,0,0,1 randomly -> identical word sequence; w_data is stable during stalls; with SCHED_STALL_CNT_EN, stall_count equals the number of low-ready valid cycles.
- load asserted on the w_index=63 handshake cycle with an all-zero block -> done=1 and next w_data=0, w_index=0, no idle cycle; load asserted mid-stream -> ignored, sequence unchanged.
- abort at w_index=20 -> w_valid=0 next cycle, no done; subsequent load restarts at W0.
- n_rst=1 at w_index=40 -> all outputs at reset values next cycle; load_ready=1.
- NUM_ROUNDS=17 build -> exactly 17 words (last W16=61626380 for "abc"), then done.
